// File: rtl/local_inject_arb_if.sv
// Bundles the PE-side request/packet lanes and the router local-port handshake.
interface local_inject_arb_if #(
  parameter int N         = 4,
  parameter int dataWidth = 32
);
  logic [N-1:0]           ReqUp;
  logic [N*dataWidth-1:0] PacketIn;
  logic [N-1:0]           GntUp;
  logic [N-1:0]           UpFull;
  logic                   ReqDnStr;
  logic                   GntDnStr;
  logic                   DnStrFull;
  logic [dataWidth-1:0]   PacketOut;
  logic [15:0]            PktCount;
  logic                   TimeoutErr;

  modport slave (
    input  ReqUp, PacketIn, GntDnStr, DnStrFull,
    output GntUp, UpFull, ReqDnStr, PacketOut, PktCount, TimeoutErr
  );

  modport master (
    output ReqUp, PacketIn, GntDnStr, DnStrFull,
    input  GntUp, UpFull, ReqDnStr, PacketOut, PktCount, TimeoutErr
  );
endinterface

// File: rtl/local_inject_arb.sv
// Round-robin arbiter funnelling N PE packets into one router local port.
// Grant/packet latch one edge after request; holds the packet until the router grants.
module local_inject_arb #(
  parameter int N         = 4,
  parameter int dataWidth = 32,
  parameter int TIMEOUT   = 255
) (
  input logic                clk,
  input logic                rst,
  local_inject_arb_if.slave  bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic {IDLE, WAIT_GNT} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        last_q;
  logic [N-1:0]         gnt_q;
  logic                 req_dn_q;
  logic [dataWidth-1:0] pkt_q;
  logic [15:0]          pkt_count_q;
  logic [7:0]           wait_cnt_q;
  logic                 err_q;

  logic [LW-1:0]        win;
  logic [LW-1:0]        idx;
  logic                 found;
  logic                 accept;
  logic                 done;

  // Search upward from the slot after the last winner so it ends up last.
  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last_q) + k) % N);
      if (!found && bus.ReqUp[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !bus.DnStrFull) begin
          accept  = 1'b1;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (bus.GntDnStr) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LW'(N - 1);
      gnt_q       <= '0;
      req_dn_q    <= 1'b0;
      pkt_q       <= '0;
      pkt_count_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= accept ? (N'(1) << win) : '0;
      if (accept) begin
        pkt_q      <= bus.PacketIn[int'(win)*dataWidth +: dataWidth];
        last_q     <= win;
        req_dn_q   <= 1'b1;
        wait_cnt_q <= '0;
      end else if (done) begin
        req_dn_q    <= 1'b0;
        pkt_count_q <= pkt_count_q + 16'd1;
        wait_cnt_q  <= '0;
      end else if (state_q == WAIT_GNT) begin
        // A same-cycle router grant takes the done branch, so the flag never races it.
        if (wait_cnt_q != TO)
          wait_cnt_q <= wait_cnt_q + 8'd1;
        if (wait_cnt_q + 8'd1 == TO || wait_cnt_q == TO)
          err_q <= 1'b1;
      end
    end
  end

  assign bus.GntUp      = gnt_q;
  assign bus.UpFull     = {N{bus.DnStrFull}};
  assign bus.ReqDnStr   = req_dn_q;
  assign bus.PacketOut  = pkt_q;
  assign bus.PktCount   = pkt_count_q;
  assign bus.TimeoutErr = err_q;
endmodule

// File: tb/tb_local_inject_arb.sv
// Bench for local_inject_arb: per-cycle vector table plus directed multi-cycle sequences.
module tb_local_inject_arb;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  local_inject_arb_if #(.N(N), .dataWidth(DW)) bus();

  local_inject_arb #(.N(N), .dataWidth(DW), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic         full;
    logic         gdn;
    logic [N-1:0] gnt;
    logic         rdn;
    logic [15:0]  cnt;
  } vec_t;

  vec_t           tv[$];
  logic [DW-1:0]  sb[$];
  int             n_vec = 0;
  int             n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] req, input logic full, input logic gdn);
    rst           = r;
    bus.ReqUp     = req;
    bus.DnStrFull = full;
    bus.GntDnStr  = gdn;
  endtask

  task automatic expect_pkt(input logic [N-1:0] gnt);
    for (int i = 0; i < N; i++)
      if (gnt[i]) sb.push_back(bus.PacketIn[i*DW +: DW]);
  endtask

  task automatic pop_pkt(input string name);
    if (bus.GntUp != '0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: grant %b with no expected packet", name, bus.GntUp);
      end else begin
        check(name, bus.PacketOut, sb.pop_front());
      end
    end
  endtask

  task automatic row(input logic r, input logic [N-1:0] req, input logic full, input logic gdn,
                     input logic [N-1:0] gnt, input logic rdn, input logic [15:0] cnt);
    tv.push_back('{r, req, full, gdn, gnt, rdn, cnt});
  endtask

  initial begin
    for (int i = 0; i < N; i++) bus.PacketIn[i*DW +: DW] = 32'hA000_0000 + 32'(i * 32'h111);
    drive(1'b1, '0, 1'b0, 1'b0);
    tick();
    tick();

    check("rst_gnt", 32'(bus.GntUp), 32'h0);
    check("rst_reqdn", 32'(bus.ReqDnStr), 32'h0);
    check("rst_pkt", bus.PacketOut, 32'h0);
    check("rst_cnt", 32'(bus.PktCount), 32'h0);
    check("rst_err", 32'(bus.TimeoutErr), 32'h0);
    check("rst_upfull", 32'(bus.UpFull), 32'h0);

    // PE2 alone
    bus.PacketIn[2*DW +: DW] = 32'h5A00_0123;
    drive(1'b0, 4'b0100, 1'b0, 1'b0);
    expect_pkt(4'b0100);
    tick();
    check("pe2_gnt", 32'(bus.GntUp), 32'h4);
    check("pe2_reqdn", 32'(bus.ReqDnStr), 32'h1);
    pop_pkt("pe2_pkt");
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    check("pe2_gnt_pulse", 32'(bus.GntUp), 32'h0);
    check("pe2_pkt_hold", bus.PacketOut, 32'h5A00_0123);
    check("pe2_reqdn_hold", 32'(bus.ReqDnStr), 32'h1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("pe2_reqdn_clr", 32'(bus.ReqDnStr), 32'h0);
    check("pe2_cnt", 32'(bus.PktCount), 32'h1);
    tick();
    check("idle_gdn_ignored", 32'(bus.PktCount), 32'h1);

    // Vector table: rotation, full backpressure, priority, sole requester
    row(1, 4'h0, 0, 0, 4'h0, 0, 0);
    row(0, 4'hF, 0, 1, 4'h1, 1, 0);
    row(0, 4'hF, 0, 1, 4'h0, 0, 1);
    row(0, 4'hF, 0, 1, 4'h2, 1, 1);
    row(0, 4'hF, 0, 1, 4'h0, 0, 2);
    row(0, 4'hF, 0, 1, 4'h4, 1, 2);
    row(0, 4'hF, 0, 1, 4'h0, 0, 3);
    row(0, 4'hF, 0, 1, 4'h8, 1, 3);
    row(0, 4'hF, 0, 1, 4'h0, 0, 4);
    row(0, 4'hF, 0, 1, 4'h1, 1, 4);
    row(0, 4'hF, 0, 1, 4'h0, 0, 5);
    row(1, 4'h0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 10; i++) row(0, 4'hF, 1, 0, 4'h0, 0, 0);
    row(0, 4'hF, 0, 0, 4'h1, 1, 0);
    row(0, 4'hF, 1, 0, 4'h0, 1, 0);
    row(0, 4'hF, 0, 1, 4'h0, 0, 1);
    row(0, 4'h5, 0, 0, 4'h4, 1, 1);
    row(0, 4'h5, 0, 1, 4'h0, 0, 2);
    row(0, 4'h5, 0, 0, 4'h1, 1, 2);
    row(0, 4'h0, 0, 1, 4'h0, 0, 3);
    row(0, 4'h0, 0, 1, 4'h0, 0, 3);
    row(0, 4'h2, 0, 1, 4'h2, 1, 3);
    row(0, 4'h2, 0, 1, 4'h0, 0, 4);
    row(0, 4'h2, 0, 1, 4'h2, 1, 4);
    row(0, 4'h0, 0, 1, 4'h0, 0, 5);

    foreach (tv[j]) begin
      drive(tv[j].r, tv[j].req, tv[j].full, tv[j].gdn);
      if (!tv[j].r) expect_pkt(tv[j].gnt);
      tick();
      check($sformatf("v%0d_gnt", j), 32'(bus.GntUp), 32'(tv[j].gnt));
      check($sformatf("v%0d_reqdn", j), 32'(bus.ReqDnStr), 32'(tv[j].rdn));
      check($sformatf("v%0d_cnt", j), 32'(bus.PktCount), 32'(tv[j].cnt));
      check($sformatf("v%0d_upfull", j), 32'(bus.UpFull), 32'({N{tv[j].full}}));
      if (tv[j].r) check($sformatf("v%0d_pkt_rst", j), bus.PacketOut, 32'h0);
      pop_pkt($sformatf("v%0d_pkt", j));
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    // Router grant in the same cycle the wait counter would hit the limit
    drive(1'b1, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    check("to15_gnt", 32'(bus.GntUp), 32'h1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (254) tick();
    check("to15_err_before", 32'(bus.TimeoutErr), 32'h0);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("to15_err_race", 32'(bus.TimeoutErr), 32'h0);
    check("to15_reqdn", 32'(bus.ReqDnStr), 32'h0);

    // Timeout: 300 waiting cycles, sticky flag
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    check("to_gnt", 32'(bus.GntUp), 32'h1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      tick();
      check($sformatf("to_err_w%0d", k), 32'(bus.TimeoutErr), 32'(k >= 255));
      check($sformatf("to_reqdn_w%0d", k), 32'(bus.ReqDnStr), 32'h1);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("to_reqdn_done", 32'(bus.ReqDnStr), 32'h0);
    check("to_err_sticky", 32'(bus.TimeoutErr), 32'h1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    check("to_err_sticky2", 32'(bus.TimeoutErr), 32'h1);

    // PktCount wrap via backdoor preload
    drive(1'b1, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    dut.pkt_count_q = 16'hFFFF;
    tick();
    check("wrap_pre", 32'(bus.PktCount), 32'hFFFF);
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("wrap_cnt", 32'(bus.PktCount), 32'h0);

    // Reset in the middle of WAIT_GNT
    drive(1'b1, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("rw_cnt1", 32'(bus.PktCount), 32'h1);
    drive(1'b0, 4'b0010, 1'b0, 1'b0);
    tick();
    check("rw_gnt_pe1", 32'(bus.GntUp), 32'h2);
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    check("rw_reqdn", 32'(bus.ReqDnStr), 32'h0);
    check("rw_pkt", bus.PacketOut, 32'h0);
    check("rw_cnt", 32'(bus.PktCount), 32'h0);
    check("rw_gnt", 32'(bus.GntUp), 32'h0);
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    tick();
    check("rw_first_gnt", 32'(bus.GntUp), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
